// File: rtl/aes_round_sequencer.sv
// Control sequencer for the iterative AES round datapath and key-expansion unit.
// Optional abort input is built in when AES_ABORT_EN is defined.
module aes_round_sequencer #(
  parameter int unsigned NR    = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             load_en,
  output logic             round_en,
  output logic             key_exp_en,
  output logic             last_round,
  output logic [CNT_W-1:0] round_idx,
  output logic [7:0]       rcon,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef AES_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       rcon_r, rcon_nxt, rcon_xt;
  logic             abort_i;

`ifdef AES_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign rcon_xt = {rcon_r[6:0], 1'b0} ^ (rcon_r[7] ? 8'h1B : 8'h00);

  // Acceptance is combinational so DONE can hand over straight into LOAD.
  always_comb begin
    start_ready = !reset && !abort_i &&
                  ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  end

  always_comb begin
    state_nxt = S_IDLE;
    cnt_nxt   = '0;
    rcon_nxt  = rcon_r;
    case (state)
      S_IDLE: begin
        if (start_valid && !abort_i) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = (NR == 1) ? S_FINAL : S_ROUND;
        cnt_nxt   = CNT_W'(1);
      end
      S_ROUND: begin
        rcon_nxt = rcon_xt;
        if (cnt == CNT_W'(NR - 1)) begin
          state_nxt = S_FINAL;
          cnt_nxt   = CNT_W'(NR);
        end else begin
          state_nxt = S_ROUND;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      S_FINAL: begin
        rcon_nxt  = rcon_xt;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = start_valid ? S_LOAD : S_IDLE;
        else           state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_i) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
    if (state_nxt == S_LOAD) rcon_nxt = 8'h01;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rcon_r     <= 8'h01;
      load_en    <= 1'b0;
      round_en   <= 1'b0;
      key_exp_en <= 1'b0;
      last_round <= 1'b0;
      round_idx  <= '0;
      rcon       <= 8'h00;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rcon_r     <= rcon_nxt;
      load_en    <= (state_nxt == S_LOAD);
      round_en   <= (state_nxt == S_ROUND) || (state_nxt == S_FINAL);
      key_exp_en <= (state_nxt == S_ROUND) || (state_nxt == S_FINAL);
      last_round <= (state_nxt == S_FINAL);
      round_idx  <= ((state_nxt == S_LOAD) || (state_nxt == S_ROUND) ||
                     (state_nxt == S_FINAL)) ? cnt_nxt : '0;
      rcon       <= ((state_nxt == S_ROUND) || (state_nxt == S_FINAL)) ? rcon_nxt : 8'h00;
      out_valid  <= (state_nxt == S_DONE);
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed scenarios plus random
// traffic checked every cycle against a block-position reference model.
module tb_aes_round_sequencer;

  localparam int unsigned NR    = 10;
  localparam int unsigned CNT_W = 4;
`ifdef AES_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             start_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             abort = 1'b0;
  logic             start_ready, load_en, round_en, key_exp_en, last_round;
  logic [CNT_W-1:0] round_idx;
  logic [7:0]       rcon;
  logic             out_valid, busy;

  aes_round_sequencer #(.NR(NR), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .load_en(load_en),
    .round_en(round_en),
    .key_exp_en(key_exp_en),
    .last_round(last_round),
    .round_idx(round_idx),
    .rcon(rcon),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef AES_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  int n_pass  = 0;
  int n_total = 0;
  // Model: -1 before first reset, 0 idle, 1 load, 2..NR+1 rounds, NR+2 done.
  int pos = -1;

  logic       s_round_en, s_out_valid;
  logic [7:0] s_rcon;
  int         s_round_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Round constant for round r: 1 doubled r-1 times in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] rcon_of(input int r);
    int t = 1;
    for (int i = 1; i < r; i++) begin
      t = t * 2;
      if (t > 255) t = t ^ 'h11B;
    end
    return t[7:0];
  endfunction

  task automatic step(input logic rst, input logic sv, input logic ordy, input logic ab);
    logic in_round;
    @(negedge clk);
    reset       = rst;
    start_valid = sv;
    out_ready   = ordy;
    abort       = ab & ABORT_ON;
    #1;
    s_round_en  = round_en;
    s_out_valid = out_valid;
    s_rcon      = rcon;
    s_round_idx = int'(round_idx);
    chk("start_ready", start_ready,
        !rst && !abort && (pos == 0 || (pos == int'(NR) + 2 && ordy)));
    if (pos >= 0) begin
      in_round = (pos >= 2) && (pos <= int'(NR) + 1);
      chk("load_en",    load_en,    pos == 1);
      chk("round_en",   round_en,   in_round);
      chk("key_exp_en", key_exp_en, in_round);
      chk("last_round", last_round, pos == int'(NR) + 1);
      chk("round_idx",  round_idx,  (pos >= 1 && pos <= int'(NR) + 1) ? pos - 1 : 0);
      chk("rcon",       rcon,       in_round ? rcon_of(pos - 1) : 8'h00);
      chk("out_valid",  out_valid,  pos == int'(NR) + 2);
      chk("busy",       busy,       pos != 0);
    end
    @(posedge clk);
    if (rst)                      pos = 0;
    else if (pos < 0)             pos = -1;
    else if (abort && pos != 0)   pos = 0;
    else if (pos == 0)            pos = (sv && !abort) ? 1 : 0;
    else if (pos <= int'(NR) + 1) pos = pos + 1;
    else if (ordy)                pos = sv ? 1 : 0;
  endtask

  initial begin
    logic [7:0] rcon_tab [10];
    logic [7:0] rq [$];
    int lat, last_ov;

    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    step(1, 0, 0, 0);
    step(1, 1, 1, 0);

    // Single block, consumer stalls in DONE for several cycles.
    step(0, 1, 0, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 0);
      if (s_round_en) rq.push_back(s_rcon);
      if (s_out_valid && lat == 0) lat = k;
    end
    chk("latency", lat, NR + 2);
    chk("rcon_count", rq.size(), 10);
    for (int i = 0; i < 10 && i < rq.size(); i++) chk("rcon_trace", rq[i], rcon_tab[i]);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Back-to-back blocks.
    last_ov = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 0);
      if (s_out_valid) begin
        if (last_ov >= 0) chk("b2b_period", i - last_ov, NR + 2);
        last_ov = i;
      end
    end
    repeat (14) step(0, 0, 1, 0);

    // Reset while round_idx is 5, then a clean block.
    step(0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_at_round5", s_round_idx, 5);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (14) step(0, 0, 1, 0);

    if (ABORT_ON) begin
      step(0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("abort_at_round3", s_round_idx, 3);
      repeat (16) step(0, 0, 1, 0);
    end

    // Random traffic.
    repeat (3000) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
